// File: rtl/lnet_pixel_binarizer.sv
// lnet_pixel_binarizer: thresholds a beat-serial grayscale pixel stream into a double-buffered 784-bit frame vector
module lnet_pixel_binarizer #(
  parameter int NUM_PIXELS  = 784,
  parameter int BEAT_PIXELS = 8,
  parameter int PIX_W       = 8,
  parameter int THRESH      = 128,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [BEAT_PIXELS*PIX_W-1:0] s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_PIXELS-1:0]        m_data,
  output logic                         err,
  output logic [CNT_W-1:0]             frames_out,
  output logic [CNT_W-1:0]             frames_drop
);
  localparam int NUM_BEATS = NUM_PIXELS / BEAT_PIXELS;
  localparam int BC_W = $clog2(NUM_BEATS);
  localparam logic [PIX_W-1:0] TH = PIX_W'(THRESH);
  typedef enum logic [1:0] {FILL, FULL, DRAIN} state_t;
  state_t                  r_state;
  logic [BC_W-1:0]         r_cnt;
  logic [NUM_PIXELS-1:0]   r_buf;
  logic [NUM_PIXELS-1:0]   r_mdata;
  logic                    r_mvalid;
  logic                    r_err;
  logic [CNT_W-1:0]        r_fout;
  logic [CNT_W-1:0]        r_fdrop;
  logic [BEAT_PIXELS-1:0]  w_bits;
  logic [NUM_PIXELS-1:0]   w_next_buf;
  logic                    w_acc;
  logic                    w_handoff;
  logic                    w_free;
  logic                    w_last_beat;
  genvar i;
  generate
    for (i = 0; i < BEAT_PIXELS; i++) begin : g_th
      assign w_bits[i] = s_data[i*PIX_W +: PIX_W] >= TH;
    end
  endgenerate
  assign s_ready     = rst && (r_state != FULL);
  assign w_acc       = s_valid && s_ready;
  assign w_handoff   = r_mvalid && m_ready;
  assign w_free      = !r_mvalid || m_ready;
  assign w_last_beat = r_cnt == BC_W'(NUM_BEATS - 1);
  assign m_valid     = r_mvalid;
  assign m_data      = r_mdata;
  assign err         = r_err;
  assign frames_out  = r_fout;
  assign frames_drop = r_fdrop;
  // assembly buffer with the current beat's thresholded bits merged in at its slot
  always_comb begin
    w_next_buf = r_buf;
    w_next_buf[int'(r_cnt)*BEAT_PIXELS +: BEAT_PIXELS] = w_bits;
  end
  // frame assembly, malformed-frame handling and output register hand-off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= FILL;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_mdata  <= '0;
      r_mvalid <= 1'b0;
      r_err    <= 1'b0;
      r_fout   <= '0;
      r_fdrop  <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_handoff) begin
        r_mvalid <= 1'b0;
        r_fout   <= r_fout + CNT_W'(1);
      end
      case (r_state)
        FILL: if (w_acc) begin
          r_buf <= w_next_buf;
          if (w_last_beat) begin
            r_cnt <= '0;
            if (!s_last) begin
              r_err   <= 1'b1;
              r_fdrop <= r_fdrop + CNT_W'(1);
              r_state <= DRAIN;
            end else if (w_free) begin
              r_mdata  <= w_next_buf;
              r_mvalid <= 1'b1;
            end else begin
              r_state <= FULL;
            end
          end else if (s_last) begin
            r_err   <= 1'b1;
            r_fdrop <= r_fdrop + CNT_W'(1);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + BC_W'(1);
          end
        end
        FULL: if (w_free) begin
          r_mdata  <= r_buf;
          r_mvalid <= 1'b1;
          r_state  <= FILL;
        end
        DRAIN: if (w_acc && s_last) r_state <= FILL;
        default: r_state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_lnet_pixel_binarizer.sv
// tb_lnet_pixel_binarizer: directed and randomized frames checked against a queue-based frame model
module tb_lnet_pixel_binarizer;
  localparam int NP = 784;
  localparam int BP = 8;
  localparam int NB = NP / BP;
  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [BP*8-1:0] s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [NP-1:0]   m_data;
  logic            err;
  logic [15:0]     frames_out;
  logic [15:0]     frames_drop;
  int              n_chk = 0;
  int              n_fail = 0;
  int              err_n = 0;
  logic            prev_err = 1'b0;
  logic [NP-1:0]   exp_q[$];
  lnet_pixel_binarizer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err(err), .frames_out(frames_out), .frames_drop(frames_drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_accept();
    int t = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 300) begin
        n_chk++;
        n_fail++;
        $error("FAIL accept_timeout: observed s_ready=0 for %0d cycles expected accept", t);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask
  // mode 0 random with threshold-edge values, 1 all 0x80, 2 alternating 0x7F/0x80
  task automatic send_frame(input int nb, input int last_at, input int mode);
    logic [BP*8-1:0] beats[$];
    logic [NP-1:0]   v = '0;
    logic [BP*8-1:0] d;
    int              pix;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int i = 0; i < BP; i++) begin
        if (mode == 1) pix = 8'h80;
        else if (mode == 2) pix = ((b*BP + i) % 2 == 0) ? 8'h7F : 8'h80;
        else begin
          case ($urandom_range(0, 4))
            0: pix = 127;
            1: pix = 128;
            2: pix = 0;
            3: pix = 255;
            default: pix = int'($urandom_range(0, 255));
          endcase
        end
        d[i*8 +: 8] = 8'(pix);
        if (b < NB) v[b*BP + i] = (pix >= 128);
      end
      beats.push_back(d);
    end
    if (nb == NB && last_at == NB) exp_q.push_back(v);
    for (int b = 0; b < nb; b++) begin
      s_valid = 1'b1;
      s_data  = beats[b];
      s_last  = (b + 1 == last_at);
      wait_accept();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rst === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL handoff_unexpected: observed vector %0h expected none", m_data);
      end else begin
        chk("handoff_data", m_data, exp_q.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    if (err === 1'b1) begin
      err_n++;
      chk("err_single", NP'(prev_err), '0);
    end
    prev_err = err;
  end
  initial begin
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b1;
    settle(3);
    chk("rst_s_ready", NP'(s_ready), '0);
    chk("rst_m_valid", NP'(m_valid), '0);
    chk("rst_err", NP'(err), '0);
    chk("rst_frames_out", NP'(frames_out), '0);
    chk("rst_frames_drop", NP'(frames_drop), '0);
    chk("rst_m_data", m_data, '0);
    rst = 1'b1;
    #1;
    chk("post_rst_s_ready", NP'(s_ready), NP'(1));
    send_frame(NB, NB, 1);
    chk("lat_m_valid", NP'(m_valid), NP'(1));
    chk("all_ones", m_data, '1);
    settle(1);
    chk("t1_frames_out", NP'(frames_out), NP'(1));
    chk("t1_m_valid_clear", NP'(m_valid), '0);
    chk("t1_no_err", NP'(err_n), '0);
    send_frame(NB, NB, 2);
    chk("alt_low_bits", NP'(m_data[1:0]), NP'(2'b10));
    chk("alt_top_bits", NP'(m_data[NP-1:NP-2]), NP'(2'b10));
    settle(1);
    for (int k = 0; k < 3; k++) send_frame(NB, NB, 0);
    settle(2);
    chk("rand_frames_out", NP'(frames_out), NP'(5));
    chk("rand_q_empty", NP'(exp_q.size()), '0);
    send_frame(50, 50, 0);
    chk("short_err", NP'(err), NP'(1));
    settle(1);
    chk("short_err_clear", NP'(err), '0);
    chk("short_drop", NP'(frames_drop), NP'(1));
    chk("short_no_valid", NP'(m_valid), '0);
    send_frame(NB, NB, 0);
    settle(1);
    chk("after_short_out", NP'(frames_out), NP'(6));
    send_frame(100, 100, 0);
    settle(1);
    chk("long_drop", NP'(frames_drop), NP'(2));
    chk("long_err_n", NP'(err_n), NP'(2));
    chk("long_no_valid", NP'(m_valid), '0);
    send_frame(NB, NB, 0);
    settle(1);
    chk("after_long_out", NP'(frames_out), NP'(7));
    m_ready = 1'b0;
    send_frame(NB, NB, 0);
    send_frame(NB, NB, 0);
    chk("stall_full_s_ready", NP'(s_ready), '0);
    chk("stall_m_valid", NP'(m_valid), NP'(1));
    chk("stall_held_f1", m_data, exp_q[0]);
    fork
      send_frame(NB, NB, 0);
      begin
        settle(10);
        chk("stall_s_ready_still", NP'(s_ready), '0);
        chk("stall_data_stable", m_data, exp_q[0]);
        m_ready = 1'b1;
      end
    join
    settle(3);
    chk("stall_q_empty", NP'(exp_q.size()), '0);
    chk("stall_frames_out", NP'(frames_out), NP'(10));
    chk("stall_err_n", NP'(err_n), NP'(2));
    m_ready = 1'b0;
    send_frame(NB, NB, 0);
    send_frame(40, 0, 0);
    chk("pre_rst_m_valid", NP'(m_valid), NP'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_m_valid", NP'(m_valid), '0);
    chk("mid_rst_out", NP'(frames_out), '0);
    chk("mid_rst_drop", NP'(frames_drop), '0);
    chk("mid_rst_err", NP'(err), '0);
    chk("mid_rst_s_ready", NP'(s_ready), '0);
    exp_q.delete();
    settle(2);
    rst = 1'b1;
    m_ready = 1'b1;
    send_frame(NB, NB, 0);
    settle(1);
    chk("post_rst_out", NP'(frames_out), NP'(1));
    chk("post_rst_drop", NP'(frames_drop), '0);
    chk("post_rst_q_empty", NP'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
